// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between an instruction-fetch
// requester (I) and a data load/store requester (D).
//
// A request seen in IDLE is granted and its owner, direction, address and
// store data are latched. The next cycle the FSM is in ACCESS and drives the
// RAM from those latched values until ram_ready completes the access or the
// timeout counter expires. Data normally wins arbitration. A starvation
// counter lets instruction fetch win once STARVE_MAX data grants in a row
// have been made while a fetch was waiting.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   iREN, iaddr         instruction fetch request and address
//   dREN, dWEN          data load / store request (both high = store)
//   daddr, dstore       data address and store data
//   ramload, ram_ready  RAM read data and completion strobe
//   ramREN, ramWEN      RAM read / write enables (only in ACCESS)
//   ramaddr, ramstore   RAM address and write data (latched at grant)
//   ihit, iload         fetch complete pulse and fetched word
//   dhit, dload         data complete pulse and loaded word
//   busy                high while in ACCESS
//   err                 sticky timeout flag, cleared only by reset
module mem_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        busy,
  output logic        err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);
  // The abort fires on the ACCESS cycle that would take the count to TIMEOUT.
  localparam logic [3:0] TO_LAST    = 4'(TIMEOUT - 1);

  state_t      state;
  logic        own_i;     // 1: instruction owns the access, 0: data
  logic        own_wr;    // 1: store, 0: load/fetch
  logic [31:0] lat_addr;
  logic [31:0] lat_store;
  logic [1:0]  starve;
  logic [3:0]  to_cnt;

  logic d_req;
  logic grant_i;
  logic done;

  assign d_req   = dREN | dWEN;
  // Instruction wins when it is the only requester or when data has starved it.
  assign grant_i = iREN & (~d_req | (starve == STARVE_LIM));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      own_i     <= 1'b0;
      own_wr    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_store <= 32'd0;
      starve    <= 2'd0;
      to_cnt    <= 4'd0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iREN | d_req) begin
            state  <= ACCESS;
            to_cnt <= 4'd0;
            if (grant_i) begin
              own_i     <= 1'b1;
              own_wr    <= 1'b0;
              lat_addr  <= iaddr;
              lat_store <= dstore;
              starve    <= 2'd0;
            end else begin
              own_i     <= 1'b0;
              own_wr    <= dWEN;
              lat_addr  <= daddr;
              lat_store <= dstore;
              if (!iREN)
                starve <= 2'd0;
              else if (starve != STARVE_LIM)
                starve <= starve + 2'd1;
            end
          end
        end
        ACCESS: begin
          if (ram_ready) begin
            state <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A reset arriving mid-access abandons it: no enables, no hit.
  assign busy     = (state == ACCESS);
  assign ramREN   = busy & ~own_wr & ~RST;
  assign ramWEN   = busy &  own_wr & ~RST;
  assign ramaddr  = lat_addr;
  assign ramstore = lat_store;

  // Completion is reported only if the owner is still asking for it.
  assign done  = busy & ram_ready & ~RST;
  assign ihit  = done &  own_i & iREN;
  assign dhit  = done & ~own_i & d_req;
  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3: consecutive data grants allowed while an instruction request waits.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum ACCESS cycles before abort.
REQ-003 SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port iREN  in  1  instruction fetch request.
REQ-006 SHALL have port iaddr  in  32  fetch address.
REQ-007 SHALL have port dREN  in  1  data load request.
REQ-008 SHALL have port dWEN  in  1  data store request.
REQ-009 SHALL have port daddr  in  32  data address.
REQ-010 SHALL have port dstore  in  32  store data.
REQ-011 SHALL have port ramload  in  32  RAM read data.
REQ-012 SHALL have port ram_ready  in  1  RAM completes current access this cycle.
REQ-013 SHALL have port ramREN  out  1  RAM read enable.
REQ-014 SHALL have port ramWEN  out  1  RAM write enable.
REQ-015 SHALL have port ramaddr  out  32  RAM address.
REQ-016 SHALL have port ramstore  out  32  RAM write data.
REQ-017 SHALL have port ihit  out  1  fetch complete, one-cycle pulse.
REQ-018 SHALL have port dhit  out  1  data access complete, one-cycle pulse.
REQ-019 SHALL have port iload  out  32  fetched word, valid with ihit.
REQ-020 SHALL have port dload  out  32  loaded word, valid with dhit.
REQ-021 SHALL have port busy  out  1  high while state is ACCESS.
REQ-022 SHALL have port err  out  1  sticky timeout flag.

Function
REQ-023 SHALL implement states IDLE and ACCESS; reset state IDLE.
REQ-024 In IDLE with any request, SHALL latch owner (I or D), type (read/write), address and store data, and enter ACCESS next cycle.
REQ-025 Arbitration in IDLE SHALL grant data over instruction, except when a 2-bit starvation counter equals STARVE_MAX and iREN is high, in which case instruction wins.
REQ-026 Starvation counter SHALL increment on each data grant made while iREN is high (saturating at STARVE_MAX), and clear on any instruction grant or on a data grant with iREN low.
REQ-027 dREN and dWEN both high SHALL be treated as a store.
REQ-028 In ACCESS, ramaddr/ramstore SHALL come from latched values; ramREN = latched read, ramWEN = latched write; in IDLE both enables SHALL be 0.
REQ-029 In ACCESS with ram_ready high, SHALL return to IDLE next cycle; ihit or dhit (per owner) SHALL be asserted combinationally that same cycle, gated by the owner's request still being high.
REQ-030 iload and dload SHALL pass ramload through; values outside a hit cycle are don't-care.
REQ-031 A requester deasserting mid-access SHALL NOT abort the RAM access; access completes, hit suppressed.
REQ-032 Minimum access latency SHALL be 2 cycles (grant cycle + ram_ready cycle); back-to-back accesses SHALL incur one IDLE cycle between them.
REQ-033 A 4-bit timeout counter SHALL clear on entering ACCESS and increment each ACCESS cycle without ram_ready; on reaching TIMEOUT, SHALL set err, return to IDLE, and assert no hit.
REQ-034 err SHALL remain set until reset; arbitration SHALL continue normally after timeout.
REQ-035 ihit and dhit SHALL never be asserted in the same cycle.

Reset
REQ-036 On RST high at a clock edge: state IDLE, starvation and timeout counters 0, err 0, latched address/data 0.
REQ-037 Outputs during and after reset until a grant: ramREN=0, ramWEN=0, ihit=0, dhit=0, busy=0, ramaddr=0, ramstore=0.
REQ-038 RST asserted during ACCESS SHALL abandon the access with no hit and IDLE the following cycle.

Verification
REQ-039 iREN=1, iaddr=0x100, ram_ready high on 2nd ACCESS cycle, ramload=0x8C220004 -> ramREN=1, ramaddr=0x100 two cycles, ihit pulse with iload=0x8C220004.
REQ-040 iREN=1 and dWEN=1 simultaneously, daddr=0x200, dstore=0xDEADBEEF -> store granted first (ramWEN=1, ramaddr=0x200, dhit), then fetch of iaddr after one IDLE cycle.
REQ-041 dREN held continuously with iREN=1, STARVE_MAX=3 -> grant order D,D,D,I,D...; ihit occurs on the fourth grant.
REQ-042 ram_ready held low 15 ACCESS cycles -> err=1, state IDLE, no hit; next request serviced normally with err still 1.
REQ-043 RST pulsed during ACCESS of a load -> no dhit, ramREN=0 next cycle, err=0, busy=0.
REQ-044 dREN dropped mid-access -> ramREN stays high until ram_ready; dhit stays 0.
